// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-master sram-like arbiter: owner ids and lock-FSM states.
package sram_arb_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LOCK_INST = 2'd1,
        ARB_LOCK_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_arb_owner_fifo.sv
// In-order owner FIFO: remembers which master issued each accepted request so the
// response can be routed back. The head is read combinationally for zero-latency return.
module sram_arb_owner_fifo #(
    parameter int OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         push_owner,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic                         head,
    output logic [$clog2(OUTSTANDING):0] count
);
    import sram_arb_pkg::*;

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING) + 1;

    logic          mem [OUTSTANDING];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(OUTSTANDING - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full    = (count_reg == CW'(OUTSTANDING));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_owner;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter with grant locking and in-order
// response routing. Define SRAM_ARB_RR_EN for round-robin ties; default is data-first priority.
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);
    import sram_arb_pkg::*;

    localparam int CW = $clog2(OUTSTANDING) + 1;

    arb_state_t    state_reg;
    arb_state_t    state_next;
    logic          grant;
    logic          grant_valid;
    logic          tie_owner;
    logic          room;
    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic [CW-1:0] fifo_count;
    logic [1:0]    req_vec;
    logic [1:0]    addr_ok_vec;
    logic [1:0]    data_ok_vec;

    assign req_vec = {data_req, inst_req};
    assign room    = (fifo_count < CW'(OUTSTANDING));
    assign accept  = s_req & s_addr_ok;
    assign pop     = s_data_ok & ~fifo_empty;

`ifdef SRAM_ARB_RR_EN
    logic rr_ptr_reg;

    // rr_ptr_reg holds the most recently accepted owner; a tie goes to the other one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr_reg <= OWNER_INST;
        else if (accept) rr_ptr_reg <= grant;
    end

    assign tie_owner = ~rr_ptr_reg;
`else
    assign tie_owner = OWNER_DATA;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ARB_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        grant       = OWNER_DATA;
        grant_valid = 1'b0;
        state_next  = state_reg;
        case (state_reg)
            ARB_LOCK_INST: begin
                grant       = OWNER_INST;
                grant_valid = inst_req;
            end
            ARB_LOCK_DATA: begin
                grant       = OWNER_DATA;
                grant_valid = data_req;
            end
            default: begin
                if (inst_req && data_req) begin
                    grant       = tie_owner;
                    grant_valid = room;
                end else if (data_req) begin
                    grant       = OWNER_DATA;
                    grant_valid = room;
                end else if (inst_req) begin
                    grant       = OWNER_INST;
                    grant_valid = room;
                end
            end
        endcase

        s_req = grant_valid & ~fifo_full & ~rst;

        // A presented but unaccepted request pins the grant until the slave takes it.
        case (state_reg)
            ARB_LOCK_INST,
            ARB_LOCK_DATA: if (s_addr_ok) state_next = ARB_IDLE;
            default: begin
                if (s_req && !s_addr_ok)
                    state_next = (grant == OWNER_INST) ? ARB_LOCK_INST : ARB_LOCK_DATA;
            end
        endcase
    end

    assign s_wr    = (grant == OWNER_DATA) ? data_wr    : inst_wr;
    assign s_size  = (grant == OWNER_DATA) ? data_size  : inst_size;
    assign s_addr  = (grant == OWNER_DATA) ? data_addr  : inst_addr;
    assign s_wdata = (grant == OWNER_DATA) ? data_wdata : inst_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign addr_ok_vec[gi] = accept & (grant == 1'(gi));
            assign data_ok_vec[gi] = pop & (fifo_head == 1'(gi));
        end
    endgenerate

    assign inst_addr_ok = addr_ok_vec[OWNER_INST];
    assign data_addr_ok = addr_ok_vec[OWNER_DATA];
    assign inst_data_ok = data_ok_vec[OWNER_INST];
    assign data_data_ok = data_ok_vec[OWNER_DATA];
    assign inst_rdata   = s_rdata;
    assign data_rdata   = s_rdata;

    sram_arb_owner_fifo #(
        .OUTSTANDING(OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_owner(grant),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model. Tie expectations follow SRAM_ARB_RR_EN.
module tb_sram_like_arbiter;

    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle_inputs;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h2000; inst_wdata = 32'hA5A5_0001;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h3000; data_wdata = 32'h5A5A_0002;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 32'h0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        inst_req = 1; data_req = 1; s_addr_ok = 1; s_data_ok = 1;
        settle();
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
        n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
        tick(); tick();
        rst = 0; s_addr_ok = 0; s_data_ok = 0;
        settle();
        // First tie after reset goes to data in both builds.
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_first_tie got=%b/%h exp=1/00003000", s_req, s_addr); end
        $display("tx reset: released, first tie presents addr=%h", s_addr);
    endtask

    task automatic test_data_read;
        do_reset();
        data_req = 1; data_addr = 32'h1000; s_addr_ok = 1;
        settle();
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h1000) begin n_fail++; $display("FAIL read_req got=%b/%h exp=1/00001000", s_req, s_addr); end
        n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL read_addr_ok got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
        tick();
        data_req = 0; s_addr_ok = 0;
        settle();
        n_cmp++; if (data_data_ok !== 1'b0) begin n_fail++; $display("FAIL read_early_ok got=%b exp=0", data_data_ok); end
        tick();
        s_data_ok = 1; s_rdata = 32'hDEADBEEF;
        settle();
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL read_data_ok got=%b exp=01", {inst_data_ok, data_data_ok}); end
        n_cmp++; if (data_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata got=%h exp=deadbeef", data_rdata); end
        $display("tx read: data addr=00001000 rdata=%h", data_rdata);
        tick();
        s_data_ok = 0;
        settle();
        n_cmp++; if (data_data_ok !== 1'b0) begin n_fail++; $display("FAIL read_single_pulse got=%b exp=0", data_data_ok); end
    endtask

    task automatic test_lock;
        do_reset();
        inst_req = 1; data_req = 1; data_wr = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h3000 || s_wr !== 1'b1) begin n_fail++; $display("FAIL lock_hold%0d got=%b/%h/%b exp=1/00003000/1", k, s_req, s_addr, s_wr); end
            n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL lock_no_ack%0d got=%b exp=00", k, {inst_addr_ok, data_addr_ok}); end
            tick();
        end
        s_addr_ok = 1;
        settle();
        n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL lock_data_acc got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
        $display("tx lock: data accepted after wait");
        tick();
        data_req = 0;
        settle();
        n_cmp++; if (s_addr !== 32'h2000 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL lock_inst_acc got=%h/%b exp=00002000/1", s_addr, inst_addr_ok); end
        $display("tx lock: inst accepted next");
        // Inst alone gets locked; data arriving later must not steal the grant.
        do_reset();
        inst_req = 1;
        settle();
        tick();
        data_req = 1;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_cmp++; if (s_addr !== 32'h2000 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL lock_inst_hold%0d got=%h/%b exp=00002000/0", k, s_addr, data_addr_ok); end
            tick();
        end
        s_addr_ok = 1;
        settle();
        n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_inst_release got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
        tick();
        inst_req = 0;
        settle();
        n_cmp++; if (s_addr !== 32'h3000 || data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL lock_data_after got=%h/%b exp=00003000/1", s_addr, data_addr_ok); end
        $display("tx lock: inst then data accepted");
    endtask

    task automatic test_full_order;
        do_reset();
        inst_req = 1; s_addr_ok = 1;
        settle();
        n_cmp++; if (s_addr !== 32'h2000 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_inst_acc got=%h/%b exp=00002000/1", s_addr, inst_addr_ok); end
        tick();
        inst_req = 0; data_req = 1;
        settle();
        n_cmp++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_data_acc got=%b exp=1", data_addr_ok); end
        tick();
        inst_req = 1;
        settle();
        n_cmp++; if (s_req !== 1'b0 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL full_blocked got=%b/%b exp=0/00", s_req, {inst_addr_ok, data_addr_ok}); end
        tick();
        s_data_ok = 1; s_rdata = 32'h1111_1111;
        settle();
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL full_ret_inst got=%b/%h exp=10/11111111", {inst_data_ok, data_data_ok}, inst_rdata); end
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass got=%b exp=0", s_req); end
        $display("tx full: inst returned, still blocked this cycle");
        tick();
        data_req = 0; s_rdata = 32'h2222_2222;
        settle();
        // Push (inst) and pop (data) together at count 1.
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL pushpop_ret got=%b/%h exp=01/22222222", {inst_data_ok, data_data_ok}, data_rdata); end
        n_cmp++; if (s_req !== 1'b1 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL pushpop_acc got=%b/%b exp=1/1", s_req, inst_addr_ok); end
        tick();
        inst_req = 0; s_rdata = 32'h3333_3333;
        settle();
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL pushpop_owner got=%b exp=10", {inst_data_ok, data_data_ok}); end
        $display("tx full: data returned, inst returned");
        tick();
        settle();
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL empty_ignore got=%b exp=00", {inst_data_ok, data_data_ok}); end
        tick();
        s_data_ok = 0;
    endtask

    task automatic test_policy;
        bit exp_own;
        bit prev_own;
        do_reset();
        inst_req = 1; data_req = 1; s_addr_ok = 1; s_data_ok = 1;
        prev_own = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef SRAM_ARB_RR_EN
            exp_own = (k % 2 == 0);
`else
            exp_own = 1'b1;
`endif
            settle();
            n_cmp++; if ({inst_addr_ok, data_addr_ok} !== {!exp_own, exp_own}) begin n_fail++; $display("FAIL policy_acc%0d got=%b exp=%b", k, {inst_addr_ok, data_addr_ok}, {!exp_own, exp_own}); end
            if (k > 0) begin
                n_cmp++; if ({inst_data_ok, data_data_ok} !== {!prev_own, prev_own}) begin n_fail++; $display("FAIL policy_ret%0d got=%b exp=%b", k, {inst_data_ok, data_data_ok}, {!prev_own, prev_own}); end
            end
            $display("tx policy: cycle %0d accepted %s", k, data_addr_ok ? "data" : "inst");
            prev_own = exp_own;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        inst_req = 1; s_addr_ok = 1;
        settle();
        n_cmp++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_acc got=%b exp=1", inst_addr_ok); end
        tick();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0; s_data_ok = 1;
        settle();
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL rmid_no_ret got=%b exp=00", {inst_data_ok, data_data_ok}); end
        tick();
        s_data_ok = 0; inst_req = 1; s_addr_ok = 1;
        settle();
        n_cmp++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_acc1 got=%b exp=1", inst_addr_ok); end
        tick();
        inst_req = 0; data_req = 1;
        settle();
        n_cmp++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_acc2 got=%b exp=1", data_addr_ok); end
        tick();
        data_req = 0; inst_req = 1;
        settle();
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rmid_full got=%b exp=0", s_req); end
        $display("tx reset_mid: stale entry discarded, two fresh accepts then full");
        idle_inputs();
    endtask

    task automatic test_random(input int cycles);
        bit          act [2];
        logic        pw  [2];
        logic [1:0]  ps  [2];
        logic [31:0] pa  [2];
        logic [31:0] pd  [2];
        bit          owner_q [$];
        bit          lock_v, lock_o, last_acc, g, gv, e_sreq, aok, dok;
        bit          e_iaok, e_daok, e_idok, e_ddok;
        for (int m = 0; m < 2; m++) begin
            act[m] = 0; pw[m] = 0; ps[m] = 0; pa[m] = 0; pd[m] = 0;
        end
        lock_v = 0; lock_o = 0; last_acc = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 2) != 0) begin
                    act[m] = 1; pw[m] = 1'($urandom_range(0, 1)); ps[m] = 2'($urandom_range(0, 2));
                    pa[m] = $urandom; pd[m] = $urandom;
                end
            end
            inst_req = act[0]; inst_wr = pw[0]; inst_size = ps[0]; inst_addr = pa[0]; inst_wdata = pd[0];
            data_req = act[1]; data_wr = pw[1]; data_size = ps[1]; data_addr = pa[1]; data_wdata = pd[1];
            aok = ($urandom_range(0, 9) < 6);
            dok = ($urandom_range(0, 9) < 5);
            s_addr_ok = aok; s_data_ok = dok; s_rdata = $urandom;
            settle();
            gv = 1; g = 0;
            if (lock_v) g = lock_o;
            else if (act[0] && act[1]) begin
`ifdef SRAM_ARB_RR_EN
                g = !last_acc;
`else
                g = 1;
`endif
            end else if (act[1]) g = 1;
            else if (act[0]) g = 0;
            else gv = 0;
            e_sreq = gv && act[g] && (owner_q.size() < OUT);
            e_iaok = e_sreq && aok && (g == 0);
            e_daok = e_sreq && aok && (g == 1);
            e_idok = dok && (owner_q.size() > 0) && (owner_q[0] == 0);
            e_ddok = dok && (owner_q.size() > 0) && (owner_q[0] == 1);
            n_cmp++; if (s_req !== e_sreq) begin n_fail++; $display("FAIL rnd_s_req c=%0d got=%b exp=%b", c, s_req, e_sreq); end
            if (e_sreq) begin
                n_cmp++;
                if ({s_wr, s_size, s_addr, s_wdata} !== {pw[g], ps[g], pa[g], pd[g]}) begin
                    n_fail++; $display("FAIL rnd_fields c=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", c, s_wr, s_size, s_addr, s_wdata, pw[g], ps[g], pa[g], pd[g]);
                end
            end
            n_cmp++; if ({inst_addr_ok, data_addr_ok} !== {e_iaok, e_daok}) begin n_fail++; $display("FAIL rnd_addr_ok c=%0d got=%b exp=%b", c, {inst_addr_ok, data_addr_ok}, {e_iaok, e_daok}); end
            n_cmp++; if ({inst_data_ok, data_data_ok} !== {e_idok, e_ddok}) begin n_fail++; $display("FAIL rnd_data_ok c=%0d got=%b exp=%b", c, {inst_data_ok, data_data_ok}, {e_idok, e_ddok}); end
            if (e_idok || e_ddok) begin
                n_cmp++; if ((e_idok ? inst_rdata : data_rdata) !== s_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, e_idok ? inst_rdata : data_rdata, s_rdata); end
                $display("tx rnd c=%0d return to %s", c, e_idok ? "inst" : "data");
            end
            tick();
            if (dok && owner_q.size() > 0) void'(owner_q.pop_front());
            if (e_sreq && aok) begin
                owner_q.push_back(g);
                act[g] = 0;
                last_acc = g;
                $display("tx rnd c=%0d accept %s addr=%h wr=%b", c, g ? "data" : "inst", pa[g], pw[g]);
            end
            if (lock_v) begin
                if (aok) lock_v = 0;
            end else if (e_sreq && !aok) begin
                lock_v = 1;
                lock_o = g;
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_data_read();
        test_lock();
        test_full_order();
        test_policy();
        test_reset_mid();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master to one-slave arbiter for the sram-like bus. It merges the core's instruction port and data port onto a single sram-like slave port, for example ahead of a single-ported bridge or a unified cache. Arbitration and grant locking keep each master's request stable until the slave accepts it. An in-order owner FIFO routes every `data_ok`/`rdata` return back to the master that issued the request.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unreturned transactions; power of two, ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_req`, `inst_wr`  in  1  instruction-master request and write flag.
- `inst_size`  in  2  transfer size.
- `inst_addr`, `inst_wdata`  in  32  address and write data.
- `inst_addr_ok`, `inst_data_ok`  out  1  request accepted; response returned.
- `inst_rdata`  out  32  read data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: the same set of ports, widths and meanings for the data master.
- `s_req`, `s_wr`  out  1  request and write flag forwarded to the slave.
- `s_size`  out  2  transfer size to the slave.
- `s_addr`, `s_wdata`  out  32  address and write data to the slave.
- `s_addr_ok`, `s_data_ok`  in  1  slave acceptance and response.
- `s_rdata`  in  32  slave read data.

## Operation
- **Grant.** A master is eligible when its `*_req` is high and the owner count is below `OUTSTANDING`.
  - Both eligible: policy per Configuration.
  - `s_*` request fields are a combinational mux of the granted master.
  - `s_req` = 0 when nothing is granted, the FIFO is full, or `rst` is high.
- **Lock FSM**, states IDLE, LOCK_INST, LOCK_DATA.
  - IDLE → LOCK_x when `s_req & ~s_addr_ok` with grant x.
  - In LOCK_x, grant is forced to x regardless of the other master.
  - LOCK_x → IDLE on `s_addr_ok`.
  - IDLE with `s_req & s_addr_ok` stays IDLE.
- **Accept.** `x_addr_ok = s_addr_ok & s_req & grant==x`. The non-granted master sees `addr_ok` = 0.
- **Owner FIFO.**
  - On acceptance, push the owner id.
  - On `s_data_ok` with the FIFO non-empty, pop; `x_data_ok` = 1 only for head owner x.
  - `s_data_ok` with the FIFO empty is a protocol error: ignored, no pop, no `data_ok`.
  - Push and pop in the same cycle leave the count unchanged.
- **Read data.** `inst_rdata` and `data_rdata` both carry `s_rdata` unconditionally; they are qualified only by the corresponding `data_ok`.
- **Writes** are tracked identically to reads, since the slave returns `data_ok` for writes.
- **Reset values.** FSM IDLE, count 0, FIFO pointers 0, round-robin pointer = INST (so the first tie goes to data). All `*_addr_ok`, `*_data_ok` and `s_req` are 0.
- **Reset mid-transaction.** Outstanding transactions are discarded; no `data_ok` is produced for them.

## Timing
- Zero added latency:
  - `x_req` → `s_req` is combinational.
  - `s_addr_ok` → `x_addr_ok` is in the same cycle.
  - `s_data_ok` → `x_data_ok` is in the same cycle.
- Count, FSM and pointers update on the rising edge after the handshake.
- **Full condition** (count == `OUTSTANDING`): `s_req` stays low until the cycle after a pop.
  - There is no same-cycle bypass, so the cycle a pop occurs at full cannot also accept.
- Throughput: one acceptance per cycle while not full.
- A master's request and response may overlap: acceptance of request N+1 and return of request N can occur in the same cycle.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - A tie goes to the master not most recently accepted.
  - The pointer updates only on an accepted handshake.
- Undefined: fixed priority, data over instruction.
- Locking and FIFO behaviour are identical in both builds.

## Structure
- Package `sram_arb_pkg`:
  - owner encoding `OWNER_INST` = 0, `OWNER_DATA` = 1;
  - lock-state encoding `ARB_IDLE`, `ARB_LOCK_INST`, `ARB_LOCK_DATA`.
- Sub-module `sram_arb_owner_fifo`: 1-bit-wide, `OUTSTANDING`-deep circular FIFO with push, pop, full, empty and head outputs, plus a `$clog2(OUTSTANDING)+1`-bit count.
- Top level holds the lock FSM, the grant logic and the muxes.

## Test plan
- Data-only read at 0x1000: slave `addr_ok` in the same cycle, `data_ok` 2 cycles later with 0xDEADBEEF → `data_data_ok` pulses once with `data_rdata` = 0xDEADBEEF; `inst_data_ok` stays 0.
- Both requests held, slave `addr_ok` delayed 3 cycles: grant stays locked to the first winner (data in the fixed build) and `s_addr` is stable → then inst is accepted.
- `OUTSTANDING`=2: accept inst, accept data, with no returns → `s_req` = 0 while full. Returns come back in order: `inst_data_ok` then `data_data_ok`, in the order pushed.
- `SRAM_ARB_RR_EN` with both masters requesting continuously and `addr_ok` always high → acceptances alternate data, inst, data, inst.
- `rst` asserted with 1 outstanding, then `s_data_ok` pulsed after release → no `*_data_ok`; count stays 0.
- Push and pop in the same cycle at count 1 → count stays 1 and the correct owner receives `data_ok`.
